control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Main decoder for the 16-bit datapath. Maps a 4-bit instruction opcode to datapath control strobes: register-file write, ALU source and op class, memory read/write, branch, and the implicit-R15 select.
- Sits between instruction decode and the execute stage.
- Outputs are registered, giving one pipeline-register boundary.

Parameters:
- None. Opcode width is fixed at 4 and ALUOP width at 2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- en  input  1  decode enable; low = hold all outputs (stall)
- opcode  input  4  instruction opcode field
- R15  output  1  second operand / compare source is implicit register R15
- ALUSrc  output  1  1 = ALU B operand from sign-extended immediate, 0 = from register
- MemToReg  output  1  1 = write-back data from memory, 0 = from ALU
- RegWrite  output  1  register-file write enable
- MemRead  output  1  data-memory read enable
- MemWrite  output  1  data-memory write enable
- Branch  output  1  PC-redirect candidate (conditional branch or jump)
- ALUOP  output  2  00 add (address/jump), 01 compare/subtract, 10 R-type (function field decides), 11 logical immediate
- ByteOp  output  1  memory access is byte-wide
- Halt  output  1  halt instruction decoded
- Illegal  output  1  opcode not in the decode table

Behaviour:
- All outputs are registered: a decode of opcode sampled at rising edge N appears after edge N (one-cycle latency).
- rst high asynchronously clears every output to 0. Outputs stay 0 while rst is high.
- en low at an edge: all outputs hold their previous values.
- Decode table, in the order R15 ALUSrc MemToReg RegWrite MemRead MemWrite Branch ALUOP ByteOp. Any output not listed for an opcode is 0.
  - 1111 R-type: 0 0 0 1 0 0 0 10 0
  - 1000 load byte: 0 1 1 1 1 0 0 00 1
  - 1001 store byte: 0 1 0 0 0 1 0 00 1
  - 1010 load word: 0 1 1 1 1 0 0 00 0
  - 1011 store word: 0 1 0 0 0 1 0 00 0
  - 1100 AND-imm: 0 1 0 1 0 0 0 11 0
  - 1101 OR-imm: 0 1 0 1 0 0 0 11 0
  - 0101 branch-less-than: 1 0 0 0 0 0 1 01 0
  - 0100 branch-greater-than: 1 0 0 0 0 0 1 01 0
  - 0110 branch-equal: 1 0 0 0 0 0 1 01 0
  - 0001 jump: 0 0 0 0 0 0 1 00 0
  - 0000 halt: all strobes 0, Halt=1
- Undefined opcodes (0010, 0011, 0111, 1110): all strobes 0, ALUOP=00, Illegal=1.
- Invariants on every cycle:
  - MemRead and MemWrite are never both 1.
  - MemToReg=1 implies MemRead=1.
  - Branch=1 implies RegWrite=0.
  - Illegal and Halt are never both 1.
- X or Z on opcode must not propagate. Treat it as an undefined opcode.

Optional Feature:
- Macro: CONTROL_HALT_LATCH_EN
- Defined:
  - Halt is sticky. After a cycle with Halt=1, every later edge forces all strobes to 0 and keeps Halt=1, regardless of opcode or en.
  - Only rst clears the sticky state.
- Not defined:
  - Halt is a plain decode. It is 1 only for cycles whose registered opcode was 0000.

Test Plan:
- Reset: assert rst mid-cycle while opcode=1111 -> all outputs 0 immediately (no clock edge needed). Deassert, next edge -> RegWrite=1, ALUOP=10, others 0.
- Table sweep at en=1, one opcode per cycle in the order 1111, 1000, 1001, 1010, 1011, 1100, 1101, 0101, 0100, 0110, 0001, 0000 -> each row matches the decode table one cycle later.
  - Examples: 1000 -> ALUSrc=1 MemToReg=1 RegWrite=1 MemRead=1 ByteOp=1. 0110 -> R15=1 Branch=1 ALUOP=01.
- Stall: load 1011, drop en, apply 1111 for 3 cycles -> MemWrite=1 ALUSrc=1 held throughout. Raise en -> next edge RegWrite=1, MemWrite=0.
- Illegal: opcodes 0010, 0011, 0111, 1110 -> Illegal=1, all strobes 0. A following 1100 -> Illegal=0, ALUSrc=1 RegWrite=1 ALUOP=11.
- Halt: opcode 0000 then 1111.
  - Without the macro -> Halt=1 for one cycle, then RegWrite=1.
  - With CONTROL_HALT_LATCH_EN -> Halt stays 1 and RegWrite stays 0 until rst.
- Invariant checker runs across all tests, including a random opcode/en stream of 1000 cycles: no MemRead&MemWrite, no Branch&RegWrite, no Illegal&Halt.

Source files
------------

// File: rtl/control_unit.sv
// Main decoder: 4-bit opcode -> registered datapath control strobes, one cycle of latency.
// Optional macro CONTROL_HALT_LATCH_EN makes Halt sticky until reset.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] opcode,
  output logic       R15,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ALUOP,
  output logic       ByteOp,
  output logic       Halt,
  output logic       Illegal
);

  typedef struct packed {
    logic       r15;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       byte_op;
    logic       halt;
    logic       illegal;
  } ctrl_t;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluCmp = 2'b01;
  localparam logic [1:0] AluRtype = 2'b10;
  localparam logic [1:0] AluLogic = 2'b11;

  ctrl_t dec;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  always_comb begin
    dec = '0;
    // Plain case with default: an X/Z opcode matches no item and decodes as illegal.
    case (opcode)
      4'b1111: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = AluRtype;
      end
      4'b1000, 4'b1010: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = AluAdd;
        dec.byte_op    = ~opcode[1];
      end
      4'b1001, 4'b1011: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = AluAdd;
        dec.byte_op   = ~opcode[1];
      end
      4'b1100, 4'b1101: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = AluLogic;
      end
      4'b0100, 4'b0101, 4'b0110: begin
        dec.r15    = 1'b1;
        dec.branch = 1'b1;
        dec.alu_op = AluCmp;
      end
      4'b0001: begin
        dec.branch = 1'b1;
        dec.alu_op = AluAdd;
      end
      4'b0000: dec.halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
`ifdef CONTROL_HALT_LATCH_EN
    if (ctrl_q.halt) begin
      // Once halted, only reset leaves this state; en and opcode are ignored.
      ctrl_d      = '0;
      ctrl_d.halt = 1'b1;
    end else if (en) begin
      ctrl_d = dec;
    end
`else
    if (en) begin
      ctrl_d = dec;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign R15      = ctrl_q.r15;
  assign ALUSrc   = ctrl_q.alu_src;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign ALUOP    = ctrl_q.alu_op;
  assign ByteOp   = ctrl_q.byte_op;
  assign Halt     = ctrl_q.halt;
  assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed and random checks for control_unit; vectors are ordered
// R15 ALUSrc MemToReg RegWrite MemRead MemWrite Branch ALUOP[1:0] ByteOp Halt Illegal.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] opcode;
  logic       R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ByteOp, Halt, Illegal;
  logic [1:0] ALUOP;

  int total = 0;
  int bad = 0;
  logic [11:0] model_q = '0;

  localparam logic [11:0] VZero  = 12'b0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [11:0] VRtype = 12'b0_0_0_1_0_0_0_10_0_0_0;
  localparam logic [11:0] VLdB   = 12'b0_1_1_1_1_0_0_00_1_0_0;
  localparam logic [11:0] VStB   = 12'b0_1_0_0_0_1_0_00_1_0_0;
  localparam logic [11:0] VLdW   = 12'b0_1_1_1_1_0_0_00_0_0_0;
  localparam logic [11:0] VStW   = 12'b0_1_0_0_0_1_0_00_0_0_0;
  localparam logic [11:0] VLogic = 12'b0_1_0_1_0_0_0_11_0_0_0;
  localparam logic [11:0] VBr    = 12'b1_0_0_0_0_0_1_01_0_0_0;
  localparam logic [11:0] VJmp   = 12'b0_0_0_0_0_0_1_00_0_0_0;
  localparam logic [11:0] VHalt  = 12'b0_0_0_0_0_0_0_00_0_1_0;
  localparam logic [11:0] VIll   = 12'b0_0_0_0_0_0_0_00_0_0_1;

  control_unit dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .opcode   (opcode),
    .R15      (R15),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOP    (ALUOP),
    .ByteOp   (ByteOp),
    .Halt     (Halt),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] table_row(input logic [3:0] op);
    case (op)
      4'b1111: return VRtype;
      4'b1000: return VLdB;
      4'b1001: return VStB;
      4'b1010: return VLdW;
      4'b1011: return VStW;
      4'b1100, 4'b1101: return VLogic;
      4'b0100, 4'b0101, 4'b0110: return VBr;
      4'b0001: return VJmp;
      4'b0000: return VHalt;
      default: return VIll;
    endcase
  endfunction

  function automatic logic [11:0] observed();
    return {R15, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOP, ByteOp, Halt,
            Illegal};
  endfunction

  task automatic chk(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic inv();
    total++;
    assert (!(MemRead && MemWrite)) else begin
      bad++;
      $error("FAIL inv_mem: got MemRead=%b MemWrite=%b want not both", MemRead, MemWrite);
    end
    total++;
    assert (!MemToReg || MemRead) else begin
      bad++;
      $error("FAIL inv_m2r: got MemToReg=%b MemRead=%b want MemRead", MemToReg, MemRead);
    end
    total++;
    assert (!(Branch && RegWrite)) else begin
      bad++;
      $error("FAIL inv_br: got Branch=%b RegWrite=%b want not both", Branch, RegWrite);
    end
    total++;
    assert (!(Illegal && Halt)) else begin
      bad++;
      $error("FAIL inv_hi: got Illegal=%b Halt=%b want not both", Illegal, Halt);
    end
  endtask

  // Drive one cycle, advance the reference model, check the invariants.
  task automatic step(input logic [3:0] op, input logic e);
    opcode = op;
    en     = e;
    @(posedge clk);
    #1;
`ifdef CONTROL_HALT_LATCH_EN
    if (model_q[1]) model_q = VHalt;
    else if (e) model_q = table_row(op);
`else
    if (e) model_q = table_row(op);
`endif
    inv();
  endtask

  initial begin
    logic [3:0] sweep [12];
    logic [3:0] undef [4];
    sweep = '{4'b1111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0101,
              4'b0100, 4'b0110, 4'b0001, 4'b0000};
    undef = '{4'b0010, 4'b0011, 4'b0111, 4'b1110};

    rst = 1'b1; en = 1'b0; opcode = 4'b0000;
    #1 chk("rst_init", VZero);
    @(negedge clk) rst = 1'b0;
    step(4'b1111, 1'b1); chk("pre_rst", VRtype);

    // Asynchronous reset mid-cycle, no clock edge in between.
    #2 rst = 1'b1;
    #1 chk("rst_async", VZero);
    @(posedge clk); #1 chk("rst_hold", VZero);
    rst = 1'b0; model_q = '0;
    step(4'b1111, 1'b1); chk("rst_release", VRtype);

    foreach (sweep[i]) begin
      step(sweep[i], 1'b1);
      chk($sformatf("sweep_%b", sweep[i]), table_row(sweep[i]));
    end

    // Reset clears halt (needed for the sticky build before further tests).
    rst = 1'b1; #1 rst = 1'b0; model_q = '0;

    step(4'b1011, 1'b1); chk("stall_load", VStW);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0); chk($sformatf("stall_hold%0d", i), VStW);
    end
    step(4'b1111, 1'b1); chk("stall_release", VRtype);

    foreach (undef[i]) begin
      step(undef[i], 1'b1);
      chk($sformatf("illegal_%b", undef[i]), VIll);
    end
    step(4'b1100, 1'b1); chk("after_illegal", VLogic);

    step(4'b0000, 1'b1); chk("halt", VHalt);
    step(4'b1111, 1'b1);
`ifdef CONTROL_HALT_LATCH_EN
    chk("halt_sticky", VHalt);
    step(4'b1000, 1'b0); chk("halt_sticky_en0", VHalt);
    step(4'b1100, 1'b1); chk("halt_sticky2", VHalt);
    rst = 1'b1; #1 chk("halt_rst", VZero);
    rst = 1'b0; model_q = '0;
    step(4'b1111, 1'b1); chk("halt_cleared", VRtype);
`else
    chk("halt_oneshot", VRtype);
`endif

    for (int i = 0; i < 1000; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      chk("rand", model_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
